// File: rtl/ball_mover_if.sv
// Ball mover port bundle: key/wall inputs in, registered ball position/direction out.
// Latency: wires only, none added.
// Backpressure: none; all signals are level or single-cycle strobes.
`timescale 1ns/1ps
interface ball_mover_if;
  logic [7:0] keycode;
  logic       BlockUp;
  logic       BlockDown;
  logic       BlockLeft;
  logic       BlockRight;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [2:0] Dir;
  logic       step;

  // Ball mover side: consumes key and wall flags, produces position.
  modport master (
    input  keycode, BlockUp, BlockDown, BlockLeft, BlockRight,
    output BallX, BallY, Dir, step
  );

  // Renderer/keyboard side: supplies key and wall flags, observes position.
  modport slave (
    output keycode, BlockUp, BlockDown, BlockLeft, BlockRight,
    input  BallX, BallY, Dir, step
  );
endinterface

// File: rtl/ball_mover.sv
// Moves a 16x16 ball one pixel per DIV frame ticks under keyboard control with wall/edge stops.
// Latency: position/step register 3 Clk after a frame_clk rising edge (2-flop sync + edge detect).
// Backpressure: none; keycode is sampled only in the move-event cycle, other values are ignored.
`timescale 1ns/1ps
module ball_mover #(
  parameter logic [9:0] X_INIT = 10'd320,
  parameter logic [9:0] Y_INIT = 10'd240,
  parameter logic [9:0] X_MAX  = 10'd624,
  parameter logic [9:0] Y_MAX  = 10'd464,
  parameter logic [3:0] DIV    = 4'd1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_clk,
  ball_mover_if.master  bus
);

  typedef enum logic [2:0] {
    STOP  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  dir_t       dir_q, dir_d, dir_pick, req;
  logic       req_vld;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       step_q, step_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sync0, sync1, sync_d, armed;
  logic [1:0] fill;
  logic       tick, move_evt;

  function automatic logic blocked(input dir_t d, input logic bu, input logic bd,
                                   input logic bl, input logic br);
    case (d)
      UP:      blocked = bu;
      DOWN:    blocked = bd;
      LEFT:    blocked = bl;
      RIGHT:   blocked = br;
      default: blocked = 1'b0;
    endcase
  endfunction

  // Synchronize frame_clk; 'armed' waits for a real low sample after reset so a
  // frame_clk that is already high when reset drops cannot fake a rising edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      sync_d <= 1'b0;
      fill   <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sync0  <= frame_clk;
      sync1  <= sync0;
      sync_d <= sync1;
      fill   <= {fill[0], 1'b1};
      armed  <= armed | (fill[1] & ~sync1);
    end
  end

  assign tick     = armed & sync1 & ~sync_d;
  assign move_evt = tick && (cnt_q == DIV - 4'd1);

  // Decode the requested direction from the HID keycode.
  always_comb begin
    req     = STOP;
    req_vld = 1'b0;
    case (bus.keycode)
      8'h1A:   begin req = UP;    req_vld = 1'b1; end
      8'h16:   begin req = DOWN;  req_vld = 1'b1; end
      8'h04:   begin req = LEFT;  req_vld = 1'b1; end
      8'h07:   begin req = RIGHT; req_vld = 1'b1; end
      default: begin req = STOP;  req_vld = 1'b0; end
    endcase
  end

  // Direction FSM next state plus the 1-pixel move; edges clamp to STOP, never wrap.
  always_comb begin
    dir_d    = dir_q;
    dir_pick = dir_q;
    x_d      = x_q;
    y_d      = y_q;
    step_d   = 1'b0;
    cnt_d    = cnt_q;
    if (tick) begin
      cnt_d = (cnt_q == DIV - 4'd1) ? 4'd0 : cnt_q + 4'd1;
    end
    if (move_evt) begin
      if (req_vld && !blocked(req, bus.BlockUp, bus.BlockDown, bus.BlockLeft, bus.BlockRight))
        dir_pick = req;
      else if (blocked(dir_q, bus.BlockUp, bus.BlockDown, bus.BlockLeft, bus.BlockRight))
        dir_pick = STOP;
      else
        dir_pick = dir_q;
      dir_d = dir_pick;
      case (dir_pick)
        UP:      if (y_q != 10'd0) begin y_d = y_q - 10'd1; step_d = 1'b1; end else dir_d = STOP;
        DOWN:    if (y_q < Y_MAX)  begin y_d = y_q + 10'd1; step_d = 1'b1; end else dir_d = STOP;
        LEFT:    if (x_q != 10'd0) begin x_d = x_q - 10'd1; step_d = 1'b1; end else dir_d = STOP;
        RIGHT:   if (x_q < X_MAX)  begin x_d = x_q + 10'd1; step_d = 1'b1; end else dir_d = STOP;
        default: dir_d = STOP;
      endcase
    end
  end

  // State register: direction, position, step strobe and frame divider.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dir_q  <= STOP;
      x_q    <= X_INIT;
      y_q    <= Y_INIT;
      step_q <= 1'b0;
      cnt_q  <= 4'd0;
    end else begin
      dir_q  <= dir_d;
      x_q    <= x_d;
      y_q    <= y_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.BallX = x_q;
  assign bus.BallY = y_q;
  assign bus.Dir   = dir_q;
  assign bus.step  = step_q;

endmodule

// File: tb/tb_ball_mover.sv
// Directed bench for ball_mover: vector table on a DIV=1 instance plus edge/reset/divider sequences.
// Latency: checks step 3 Clk after each frame_clk rise.
// Backpressure: n/a; all stimulus is driven on the falling clock edge.
`timescale 1ns/1ps
module tb_ball_mover;

  logic clk = 1'b0;
  logic rst1, rst2;
  logic fclk1, fclk2;
  int   n_vec = 0;
  int   n_err = 0;

  ball_mover_if bus1 ();
  ball_mover_if bus2 ();

  ball_mover #(.DIV(4'd1)) dut1 (.Clk(clk), .Reset(rst1), .frame_clk(fclk1), .bus(bus1));
  ball_mover #(.DIV(4'd3)) dut2 (.Clk(clk), .Reset(rst2), .frame_clk(fclk2), .bus(bus2));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;
    logic [3:0] blk;   // {up, down, left, right}
    int         x;
    int         y;
    int         dir;
    int         steps;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input int which);
    @(negedge clk);
    if (which == 1) rst1 = 1'b1; else rst2 = 1'b1;
    repeat (2) @(negedge clk);
    if (which == 1) rst1 = 1'b0; else rst2 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // One frame_clk pulse; counts step pulses and records the cycle of the last one.
  task automatic frame(input int which, output int ns, output int lat);
    logic s;
    ns  = 0;
    lat = 0;
    @(negedge clk);
    if (which == 1) fclk1 = 1'b1; else fclk2 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      s = (which == 1) ? bus1.step : bus2.step;
      if (s) begin
        ns++;
        lat = k;
      end
    end
    if (which == 1) fclk1 = 1'b0; else fclk2 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, lat, cnt;

    // key, {U,D,L,R}, x, y, dir, steps
    vt[0]  = '{8'h07, 4'b0000, 321, 240, 4, 1};  // start RIGHT
    vt[1]  = '{8'h07, 4'b0000, 322, 240, 4, 1};
    vt[2]  = '{8'h07, 4'b0000, 323, 240, 4, 1};
    vt[3]  = '{8'h00, 4'b0000, 324, 240, 4, 1};  // key released, keeps moving
    vt[4]  = '{8'h04, 4'b0000, 323, 240, 3, 1};  // reversal
    vt[5]  = '{8'h1A, 4'b0000, 323, 239, 1, 1};  // turn UP
    vt[6]  = '{8'h04, 4'b0010, 323, 238, 1, 1};  // LEFT requested but blocked
    vt[7]  = '{8'h04, 4'b0000, 322, 238, 3, 1};  // block clears, turn LEFT
    vt[8]  = '{8'h00, 4'b0010, 322, 238, 0, 0};  // hits wall -> STOP
    vt[9]  = '{8'h55, 4'b0000, 322, 238, 0, 0};  // unknown key, stays stopped
    vt[10] = '{8'h16, 4'b0100, 322, 238, 0, 0};  // DOWN blocked while stopped
    vt[11] = '{8'h16, 4'b0000, 322, 239, 2, 1};  // DOWN
    vt[12] = '{8'h1A, 4'b1100, 322, 239, 0, 0};  // req and current both blocked

    rst1 = 1'b1; rst2 = 1'b1; fclk1 = 1'b0; fclk2 = 1'b0;
    bus1.keycode = 8'h00;
    {bus1.BlockUp, bus1.BlockDown, bus1.BlockLeft, bus1.BlockRight} = 4'b0000;
    bus2.keycode = 8'h00;
    {bus2.BlockUp, bus2.BlockDown, bus2.BlockLeft, bus2.BlockRight} = 4'b0000;
    repeat (3) @(negedge clk);
    rst1 = 1'b0; rst2 = 1'b0;

    do_reset(1);
    chk("reset_x", int'(bus1.BallX), 320);
    chk("reset_y", int'(bus1.BallY), 240);
    chk("reset_dir", int'(bus1.Dir), 0);
    chk("reset_step", int'(bus1.step), 0);

    for (int i = 0; i < 13; i++) begin
      bus1.keycode = vt[i].key;
      {bus1.BlockUp, bus1.BlockDown, bus1.BlockLeft, bus1.BlockRight} = vt[i].blk;
      frame(1, ns, lat);
      chk($sformatf("vec%0d_x", i), int'(bus1.BallX), vt[i].x);
      chk($sformatf("vec%0d_y", i), int'(bus1.BallY), vt[i].y);
      chk($sformatf("vec%0d_dir", i), int'(bus1.Dir), vt[i].dir);
      chk($sformatf("vec%0d_steps", i), ns, vt[i].steps);
      if (vt[i].steps == 1) chk($sformatf("vec%0d_lat", i), lat, 3);
    end
    {bus1.BlockUp, bus1.BlockDown, bus1.BlockLeft, bus1.BlockRight} = 4'b0000;

    // Move right to 400, then a wall appears on the right.
    do_reset(1);
    bus1.keycode = 8'h07;
    for (int i = 0; i < 80; i++) frame(1, ns, lat);
    chk("run_x400", int'(bus1.BallX), 400);
    bus1.BlockRight = 1'b1;
    frame(1, ns, lat);
    chk("wall_dir", int'(bus1.Dir), 0);
    chk("wall_x", int'(bus1.BallX), 400);
    chk("wall_steps", ns, 0);
    bus1.BlockRight = 1'b0;

    // Right screen edge clamp.
    for (int i = 0; i < 300 && bus1.BallX != 10'd624; i++) frame(1, ns, lat);
    chk("edge_reach_x", int'(bus1.BallX), 624);
    chk("edge_reach_dir", int'(bus1.Dir), 4);
    frame(1, ns, lat);
    chk("edge_x", int'(bus1.BallX), 624);
    chk("edge_dir", int'(bus1.Dir), 0);
    chk("edge_steps", ns, 0);

    // Top edge clamp: no wrap to 1023.
    bus1.keycode = 8'h1A;
    for (int i = 0; i < 300 && bus1.BallY != 10'd0; i++) frame(1, ns, lat);
    chk("top_reach_y", int'(bus1.BallY), 0);
    frame(1, ns, lat);
    chk("top_y", int'(bus1.BallY), 0);
    chk("top_dir", int'(bus1.Dir), 0);
    chk("top_steps", ns, 0);

    // Reset coincident with a tick while moving LEFT.
    bus1.keycode = 8'h04;
    @(negedge clk); fclk1 = 1'b1;
    @(negedge clk);
    @(negedge clk); rst1 = 1'b1;
    @(negedge clk);
    chk("rst_tick_x", int'(bus1.BallX), 320);
    chk("rst_tick_y", int'(bus1.BallY), 240);
    chk("rst_tick_dir", int'(bus1.Dir), 0);
    chk("rst_tick_step", int'(bus1.step), 0);
    rst1 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus1.step) cnt++;
    end
    chk("rst_held_high_steps", cnt, 0);
    chk("rst_held_high_x", int'(bus1.BallX), 320);
    fclk1 = 1'b0;
    repeat (4) @(negedge clk);
    bus1.keycode = 8'h00;
    frame(1, ns, lat);
    chk("post_rst_steps", ns, 0);
    chk("post_rst_x", int'(bus1.BallX), 320);
    chk("post_rst_dir", int'(bus1.Dir), 0);
    bus1.keycode = 8'h04;
    frame(1, ns, lat);
    chk("rearm_x", int'(bus1.BallX), 319);
    chk("rearm_dir", int'(bus1.Dir), 3);

    // Divider: DIV=3 moves only on every third frame edge.
    do_reset(2);
    bus2.keycode = 8'h16;
    for (int e = 1; e <= 6; e++) begin
      frame(2, ns, lat);
      chk($sformatf("div3_edge%0d_steps", e), ns, (e % 3 == 0) ? 1 : 0);
    end
    chk("div3_y", int'(bus2.BallY), 242);
    chk("div3_x", int'(bus2.BallX), 320);
    chk("div3_dir", int'(bus2.Dir), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ball_mover.md
BALL_MOVER -- requirements
Module: ball_mover

Interface
REQ-001 Parameters SHALL be: X_INIT 10'd320, initial BallX; Y_INIT 10'd240, initial BallY; X_MAX 10'd624, largest legal BallX; Y_MAX 10'd464, largest legal BallY; DIV 4'd1, frame ticks per 1-pixel step (1..15).
REQ-002 Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-004 frame_clk  input  1  vertical-sync-rate strobe, asynchronous to Clk.
REQ-005 keycode  input  8  USB HID keycode: 0x1A up (W), 0x16 down (S), 0x04 left (A), 0x07 right (D); any other value means no request.
REQ-006 BlockUp, BlockDown, BlockLeft, BlockRight  input  1 each  1 = wall pixel adjacent to the 16x16 ball on that side; combinational from current BallX/BallY.
REQ-007 BallX, BallY  output  10 each  top-left corner of the 16x16 ball, registered.
REQ-008 Dir  output  3  registered state: 0 STOP, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT.
REQ-009 step  output  1  one-Clk pulse in the cycle BallX/BallY change.

Function
REQ-010 frame_clk SHALL pass through a 2-flop synchronizer; tick SHALL be a one-Clk pulse on the synchronized rising edge, 3 Clk after frame_clk rises.
REQ-011 A DIV counter SHALL count ticks 0..DIV-1; a move event SHALL occur on the tick where the counter equals DIV-1, and the counter SHALL then wrap to 0.
REQ-012 Requested direction req SHALL be decoded combinationally from keycode and SHALL be sampled only in the move-event cycle.
REQ-013 In a move-event cycle: if req is valid and its Block input is 0, Dir SHALL become req; else if Dir's Block input is 1, Dir SHALL become STOP; else Dir SHALL hold.
REQ-014 Position SHALL update in the same move-event cycle using the newly chosen direction: UP BallY-1, DOWN BallY+1, LEFT BallX-1, RIGHT BallX+1, STOP no change.
REQ-015 step SHALL be 1 only when the position actually changes.
REQ-016 Block inputs SHALL be evaluated for the current (pre-update) position; the block makes no more than one 1-pixel move per event.
REQ-017 Clamping: a move SHALL be suppressed and Dir SHALL become STOP if it would make BallY < 0, BallY > Y_MAX, BallX < 0 or BallX > X_MAX; arithmetic SHALL never wrap modulo 1024.
REQ-018 Releasing keys (keycode not in REQ-005) SHALL NOT stop the ball; motion continues until it is blocked or clamped.
REQ-019 Reversal (e.g. RIGHT to LEFT) SHALL be allowed in one event, subject to REQ-013.
REQ-020 Outside move-event cycles, BallX, BallY, Dir and the DIV counter SHALL hold.
REQ-021 keycode changes between events SHALL have no effect; only the value present in the move-event cycle counts.

Reset
REQ-022 When Reset=1 on a rising Clk edge: BallX=X_INIT, BallY=Y_INIT, Dir=STOP, step=0, DIV counter=0, synchronizer flops=0.
REQ-023 Reset SHALL take priority over a coincident tick; the first move event after reset SHALL need a new frame_clk rising edge.
REQ-024 Reset during motion SHALL abort the motion in that cycle with no partial position update.

Verification
REQ-025 Reset, DIV=1, keycode=0x07, no blocks, 3 frame_clk edges -> Dir=RIGHT, BallX=323, BallY=240; step pulses 3 times, each 3 Clk after its edge.
REQ-026 Moving RIGHT at BallX=400; BlockRight=1 before the next edge -> Dir=STOP, BallX stays 400, no step pulse.
REQ-027 Moving UP; keycode=0x04 with BlockLeft=1 -> Dir stays UP, BallY decrements; BlockLeft drops to 0 -> next event Dir=LEFT, BallX-1.
REQ-028 BallX=624 moving RIGHT, no blocks -> Dir=STOP, BallX=624; likewise BallY=0 moving UP -> stays 0, no wrap to 1023.
REQ-029 DIV=3, keycode=0x16, 6 frame_clk edges -> BallY=242; steps occur only on edges 3 and 6.
REQ-030 Reset asserted in the same Clk as a tick while moving LEFT -> BallX=320, BallY=240, Dir=STOP; next edge with keycode=0 -> no movement.
